// File: rtl/decode_control_pipe.sv
// Registered LEGv8 decode/control stage with valid/ready handshakes,
// immediate generation, illegal-opcode flag and load-use interlock.
module decode_control_pipe #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ZERO_REG       = 31,
  parameter int LOAD_BUBBLES   = 1
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      flush,
  input  logic                      instrValid,
  input  logic [31:0]               instruction,
  output logic                      instrReady,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      unconditionalBranch,
  output logic                      branch,
  output logic                      memRead,
  output logic                      memToReg,
  output logic                      memWrite,
  output logic                      aluSRC,
  output logic                      regWriteFlag,
  output logic                      illegal,
  output logic [3:0]                aluControlCode,
  output logic [REG_ADDR_WIDTH-1:0] readRegister1,
  output logic [REG_ADDR_WIDTH-1:0] readRegister2,
  output logic [REG_ADDR_WIDTH-1:0] writeRegister,
  output logic [DATA_WIDTH-1:0]     immediate
);

  localparam int BW = $clog2(LOAD_BUBBLES + 2);
  localparam int RW = REG_ADDR_WIDTH;

  typedef struct packed {
    logic            ub;
    logic            br;
    logic            mrd;
    logic            m2r;
    logic            mwr;
    logic            asrc;
    logic            rw;
    logic            ill;
    logic [3:0]      alu;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [DATA_WIDTH-1:0] imm;
  } bundle_t;

  function automatic logic [RW-1:0] reg_id(input logic [4:0] f);
    logic [31:0] w;
    w = {27'b0, f};
    return w[RW-1:0];
  endfunction

  bundle_t       dec;
  bundle_t       bundle_q, bundle_d;
  logic          out_valid_q, out_valid_d;
  logic          pend_q, pend_d;
  logic [RW-1:0] pend_reg_q, pend_reg_d;
  logic [BW-1:0] bubble_q, bubble_d;
  logic          uses1, uses2, is_ld;
  logic          hazard, can_adv, accept;

  logic [10:0] op11;
  logic [9:0]  op10;
  assign op11 = instruction[31:21];
  assign op10 = instruction[31:22];

  always_comb begin
    dec       = '0;
    dec.rs1   = reg_id(instruction[9:5]);
    dec.rs2   = reg_id(instruction[20:16]);
    dec.rd    = reg_id(instruction[4:0]);
    uses1     = 1'b1;
    uses2     = 1'b0;
    is_ld     = 1'b0;
    unique case (1'b1)
      op11 == 11'b10001011000: begin
        dec.rw = 1'b1; dec.alu = 4'b0010; uses2 = 1'b1;
      end
      op11 == 11'b11001011000: begin
        dec.rw = 1'b1; dec.alu = 4'b0110; uses2 = 1'b1;
      end
      op11 == 11'b10001010000: begin
        dec.rw = 1'b1; dec.alu = 4'b0000; uses2 = 1'b1;
      end
      op11 == 11'b10101010000: begin
        dec.rw = 1'b1; dec.alu = 4'b0001; uses2 = 1'b1;
      end
      op10 == 10'b1001000100: begin
        dec.asrc = 1'b1; dec.rw = 1'b1; dec.alu = 4'b0010;
        dec.imm  = {{(DATA_WIDTH-12){1'b0}}, instruction[21:10]};
      end
      op10 == 10'b1101000100: begin
        dec.asrc = 1'b1; dec.rw = 1'b1; dec.alu = 4'b0110;
        dec.imm  = {{(DATA_WIDTH-12){1'b0}}, instruction[21:10]};
      end
      op11 == 11'b11111000010: begin
        dec.mrd = 1'b1; dec.m2r = 1'b1; dec.asrc = 1'b1;
        dec.rw  = 1'b1; dec.alu = 4'b0010; is_ld = 1'b1;
        dec.imm = {{(DATA_WIDTH-9){instruction[20]}}, instruction[20:12]};
      end
      op11 == 11'b11111000000: begin
        dec.mwr = 1'b1; dec.asrc = 1'b1; dec.alu = 4'b0010;
        dec.rs2 = reg_id(instruction[4:0]); uses2 = 1'b1;
        dec.imm = {{(DATA_WIDTH-9){instruction[20]}}, instruction[20:12]};
      end
      instruction[31:25] == 7'b1011010: begin
        dec.br  = 1'b1; dec.alu = 4'b0111;
        dec.rs2 = reg_id(instruction[4:0]); uses2 = 1'b1;
        dec.imm = {{(DATA_WIDTH-19){instruction[23]}}, instruction[23:5]};
      end
      instruction[31:26] == 6'b000101: begin
        dec.ub  = 1'b1; uses1 = 1'b0;
        dec.imm = {{(DATA_WIDTH-26){instruction[25]}}, instruction[25:0]};
      end
      default: dec.ill = 1'b1;
    endcase
  end

  assign hazard = (LOAD_BUBBLES > 0) && pend_q && instrValid &&
                  ((uses1 && dec.rs1 == pend_reg_q) ||
                   (uses2 && dec.rs2 == pend_reg_q));
  assign can_adv    = !out_valid_q || outReady;
  assign instrReady = resetN && !flush && (bubble_q == '0) &&
                      !hazard && can_adv;
  assign accept     = instrValid && instrReady;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    pend_d      = pend_q;
    pend_reg_d  = pend_reg_q;
    bubble_d    = bubble_q;
    if (flush) begin
      out_valid_d = 1'b0;
      bubble_d    = '0;
      pend_d      = 1'b0;
    end else begin
      if (bubble_q != '0) begin
        bubble_d = bubble_q - BW'(1);
        if (bubble_q == BW'(1)) pend_d = 1'b0;
      end
      if (accept) begin
        bundle_d    = dec;
        out_valid_d = 1'b1;
        pend_d      = (LOAD_BUBBLES > 0) && is_ld &&
                      (dec.rd != RW'(ZERO_REG));
        pend_reg_d  = dec.rd;
      end else if (outReady) begin
        out_valid_d = 1'b0;
      end
      // The hazard cycle itself is the first of the inserted bubbles.
      if (hazard && can_adv && bubble_q == '0) begin
        bubble_d = BW'(LOAD_BUBBLES - 1);
        pend_d   = (LOAD_BUBBLES > 1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      bundle_q    <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_reg_q  <= '0;
      bubble_q    <= '0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
      pend_reg_q  <= pend_reg_d;
      bubble_q    <= bubble_d;
    end
  end

  assign outValid            = out_valid_q;
  assign unconditionalBranch = bundle_q.ub;
  assign branch              = bundle_q.br;
  assign memRead             = bundle_q.mrd;
  assign memToReg            = bundle_q.m2r;
  assign memWrite            = bundle_q.mwr;
  assign aluSRC              = bundle_q.asrc;
  assign regWriteFlag        = bundle_q.rw;
  assign illegal             = bundle_q.ill;
  assign aluControlCode      = bundle_q.alu;
  assign readRegister1       = bundle_q.rs1;
  assign readRegister2       = bundle_q.rs2;
  assign writeRegister       = bundle_q.rd;
  assign immediate           = bundle_q.imm;

endmodule

// File: tb/tb_decode_control_pipe.sv
// Directed-vector bench for decode_control_pipe: decode, handshake,
// load-use interlock, flush and reset behaviour.
module tb_decode_control_pipe;

  logic        clock;
  logic        resetN;
  logic        flush;
  logic        instrValid;
  logic [31:0] instruction;
  logic        instrReady;
  logic        outValid;
  logic        outReady;
  logic        unconditionalBranch, branch, memRead, memToReg;
  logic        memWrite, aluSRC, regWriteFlag, illegal;
  logic [3:0]  aluControlCode;
  logic [4:0]  readRegister1, readRegister2, writeRegister;
  logic [63:0] immediate;

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] ADD_123 = 32'h8B02_0023;
  localparam logic [31:0] SUB_123 = 32'hCB02_0023;
  localparam logic [31:0] ORR_123 = 32'hAA02_0023;
  localparam logic [31:0] ADDI_10 = 32'h9100_2822;
  localparam logic [31:0] LDUR_5  = 32'hF840_8025;
  localparam logic [31:0] ADD_5   = 32'h8B02_00A6;
  localparam logic [31:0] LDUR_31 = 32'hF840_803F;
  localparam logic [31:0] ADD_31  = 32'h8B02_03E0;
  localparam logic [31:0] CBZ_W   = 32'hB4FF_FFC5;
  localparam logic [31:0] B_W     = 32'h1400_0004;
  localparam logic [31:0] STUR_W  = 32'hF800_0025;

  decode_control_pipe dut (
    .clock               (clock),
    .resetN              (resetN),
    .flush               (flush),
    .instrValid          (instrValid),
    .instruction         (instruction),
    .instrReady          (instrReady),
    .outValid            (outValid),
    .outReady            (outReady),
    .unconditionalBranch (unconditionalBranch),
    .branch              (branch),
    .memRead             (memRead),
    .memToReg            (memToReg),
    .memWrite            (memWrite),
    .aluSRC              (aluSRC),
    .regWriteFlag        (regWriteFlag),
    .illegal             (illegal),
    .aluControlCode      (aluControlCode),
    .readRegister1       (readRegister1),
    .readRegister2       (readRegister2),
    .writeRegister       (writeRegister),
    .immediate           (immediate)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0; flush = 1'b0; instrValid = 1'b0;
    instruction = '0; outReady = 1'b1;
    #3;
    nvec++;
    if ({outValid, instrReady, unconditionalBranch, branch, memRead,
         memToReg, memWrite, aluSRC, regWriteFlag, illegal} !== 10'b0) begin
      nerr++;
      $display("FAIL reset_flags got %b want 0", {outValid, instrReady,
               unconditionalBranch, branch, memRead, memToReg, memWrite,
               aluSRC, regWriteFlag, illegal});
    end
    nvec++;
    if ({aluControlCode, readRegister1, readRegister2, writeRegister,
         immediate} !== '0) begin
      nerr++;
      $display("FAIL reset_fields got alu=%h imm=%h want 0",
               aluControlCode, immediate);
    end
    tick(); tick();
    @(negedge clock);
    resetN = 1'b1;
    #1;
    nvec++;
    if (instrReady !== 1'b1) begin
      nerr++; $display("FAIL reset_release_ready got %b want 1", instrReady);
    end
  endtask

  task automatic test_add_throughput();
    instruction = ADD_123; instrValid = 1'b1;
    tick();
    nvec++;
    if ({outValid, regWriteFlag, aluControlCode, readRegister1,
         readRegister2, writeRegister} !==
        {1'b1, 1'b1, 4'b0010, 5'd1, 5'd2, 5'd3}) begin
      nerr++;
      $display("FAIL add_bundle got v=%b rw=%b alu=%b r1=%0d r2=%0d wr=%0d want 1 1 0010 1 2 3",
               outValid, regWriteFlag, aluControlCode, readRegister1,
               readRegister2, writeRegister);
    end
    instruction = SUB_123;
    #1;
    nvec++;
    if (instrReady !== 1'b1) begin
      nerr++; $display("FAIL sub_ready got %b want 1", instrReady);
    end
    tick();
    nvec++;
    if ({outValid, aluControlCode} !== {1'b1, 4'b0110}) begin
      nerr++;
      $display("FAIL sub_alu got v=%b alu=%b want 1 0110",
               outValid, aluControlCode);
    end
    instruction = ORR_123;
    tick();
    nvec++;
    if ({outValid, aluControlCode} !== {1'b1, 4'b0001}) begin
      nerr++;
      $display("FAIL orr_alu got v=%b alu=%b want 1 0001",
               outValid, aluControlCode);
    end
    instruction = ADDI_10;
    tick();
    nvec++;
    if ({aluSRC, regWriteFlag, aluControlCode, writeRegister, immediate} !==
        {1'b1, 1'b1, 4'b0010, 5'd2, 64'd10}) begin
      nerr++;
      $display("FAIL addi_bundle got src=%b rw=%b alu=%b wr=%0d imm=%h want 1 1 0010 2 a",
               aluSRC, regWriteFlag, aluControlCode, writeRegister, immediate);
    end
    instrValid = 1'b0;
    tick();
    nvec++;
    if (outValid !== 1'b0) begin
      nerr++; $display("FAIL drain_valid got %b want 0", outValid);
    end
  endtask

  task automatic test_load_use();
    instruction = LDUR_5; instrValid = 1'b1;
    tick();
    nvec++;
    if ({outValid, memRead, memToReg, aluSRC, regWriteFlag, aluControlCode,
         writeRegister, immediate} !==
        {5'b11111, 4'b0010, 5'd5, 64'd8}) begin
      nerr++;
      $display("FAIL ldur_bundle got v=%b mr=%b m2r=%b alu=%b wr=%0d imm=%h want 1 1 1 0010 5 8",
               outValid, memRead, memToReg, aluControlCode, writeRegister,
               immediate);
    end
    instruction = ADD_5;
    #1;
    nvec++;
    if (instrReady !== 1'b0) begin
      nerr++; $display("FAIL hazard_ready got %b want 0", instrReady);
    end
    tick();
    nvec++;
    if ({outValid, instrReady} !== 2'b01) begin
      nerr++;
      $display("FAIL bubble got v=%b rdy=%b want 0 1", outValid, instrReady);
    end
    tick();
    nvec++;
    if ({outValid, readRegister1, writeRegister} !== {1'b1, 5'd5, 5'd6}) begin
      nerr++;
      $display("FAIL add_after_ld got v=%b r1=%0d wr=%0d want 1 5 6",
               outValid, readRegister1, writeRegister);
    end
    instruction = LDUR_31;
    tick();
    instruction = ADD_31;
    #1;
    nvec++;
    if (instrReady !== 1'b1) begin
      nerr++; $display("FAIL zero_reg_ready got %b want 1", instrReady);
    end
    tick();
    nvec++;
    if ({outValid, readRegister1} !== {1'b1, 5'd31}) begin
      nerr++;
      $display("FAIL zero_reg_add got v=%b r1=%0d want 1 31",
               outValid, readRegister1);
    end
    instrValid = 1'b0;
    tick();
  endtask

  task automatic test_cbz_b();
    instruction = CBZ_W; instrValid = 1'b1;
    tick();
    nvec++;
    if ({outValid, branch, regWriteFlag, readRegister2, aluControlCode,
         immediate} !==
        {3'b110, 5'd5, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      nerr++;
      $display("FAIL cbz_bundle got br=%b rw=%b r2=%0d alu=%b imm=%h want 1 0 5 0111 fffffffffffffffe",
               branch, regWriteFlag, readRegister2, aluControlCode, immediate);
    end
    instruction = B_W;
    tick();
    nvec++;
    if ({outValid, unconditionalBranch, branch, immediate} !==
        {3'b110, 64'd4}) begin
      nerr++;
      $display("FAIL b_bundle got ub=%b br=%b imm=%h want 1 0 4",
               unconditionalBranch, branch, immediate);
    end
    instrValid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    instruction = STUR_W; instrValid = 1'b1;
    tick();
    instruction = ADD_123;
    #1;
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if ({outValid, memWrite, regWriteFlag, readRegister2, immediate,
           instrReady} !== {3'b110, 5'd5, 64'd0, 1'b0}) begin
        nerr++;
        $display("FAIL stur_hold%0d got v=%b mw=%b r2=%0d imm=%h rdy=%b want 1 1 5 0 0",
                 i, outValid, memWrite, readRegister2, immediate, instrReady);
      end
      tick();
    end
    outReady = 1'b1;
    #1;
    nvec++;
    if (instrReady !== 1'b1) begin
      nerr++; $display("FAIL release_ready got %b want 1", instrReady);
    end
    tick();
    nvec++;
    if ({outValid, regWriteFlag, memWrite, writeRegister} !==
        {3'b110, 5'd3}) begin
      nerr++;
      $display("FAIL release_add got v=%b rw=%b mw=%b wr=%0d want 1 1 0 3",
               outValid, regWriteFlag, memWrite, writeRegister);
    end
    instrValid = 1'b0;
    tick();
    nvec++;
    if (outValid !== 1'b0) begin
      nerr++; $display("FAIL release_drain got %b want 0", outValid);
    end
  endtask

  task automatic test_flush();
    instruction = LDUR_5; instrValid = 1'b1;
    tick();
    instruction = ADD_5; flush = 1'b1;
    #1;
    nvec++;
    if (instrReady !== 1'b0) begin
      nerr++; $display("FAIL flush_ready got %b want 0", instrReady);
    end
    tick();
    nvec++;
    if (outValid !== 1'b0) begin
      nerr++; $display("FAIL flush_valid got %b want 0", outValid);
    end
    flush = 1'b0;
    #1;
    nvec++;
    if (instrReady !== 1'b1) begin
      nerr++; $display("FAIL post_flush_ready got %b want 1", instrReady);
    end
    tick();
    nvec++;
    if ({outValid, readRegister1, writeRegister} !== {1'b1, 5'd5, 5'd6}) begin
      nerr++;
      $display("FAIL post_flush_add got v=%b r1=%0d wr=%0d want 1 5 6",
               outValid, readRegister1, writeRegister);
    end
    instrValid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    instruction = 32'h0000_0000; instrValid = 1'b1;
    tick();
    nvec++;
    if ({outValid, illegal, regWriteFlag, memWrite, branch, memRead,
         unconditionalBranch, aluControlCode, immediate} !==
        {2'b11, 5'b0, 4'b0, 64'd0}) begin
      nerr++;
      $display("FAIL illegal_bundle got v=%b ill=%b rw=%b mw=%b br=%b alu=%b imm=%h want 1 1 0 0 0 0 0",
               outValid, illegal, regWriteFlag, memWrite, branch,
               aluControlCode, immediate);
    end
    instrValid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    instruction = LDUR_5; instrValid = 1'b1;
    tick();
    instruction = ADD_5;
    #2;
    nvec++;
    if (instrReady !== 1'b0) begin
      nerr++; $display("FAIL stall_ready got %b want 0", instrReady);
    end
    resetN = 1'b0;
    #1;
    nvec++;
    if ({outValid, instrReady, memRead, memToReg, regWriteFlag,
         writeRegister, immediate} !== '0) begin
      nerr++;
      $display("FAIL async_reset got v=%b rdy=%b mr=%b wr=%0d imm=%h want 0",
               outValid, instrReady, memRead, writeRegister, immediate);
    end
    @(negedge clock);
    resetN = 1'b1;
    #1;
    nvec++;
    if (instrReady !== 1'b1) begin
      nerr++; $display("FAIL after_reset_ready got %b want 1", instrReady);
    end
    tick();
    nvec++;
    if ({outValid, readRegister1} !== {1'b1, 5'd5}) begin
      nerr++;
      $display("FAIL after_reset_add got v=%b r1=%0d want 1 5",
               outValid, readRegister1);
    end
    instrValid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add_throughput();
    test_load_use();
    test_cbz_b();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
